// File: rtl/chip8_keypad_scanner_if.sv
// Keypad pin signals and core-facing key reporting of the CHIP-8 keypad scanner.
// The master side is the scanner. The slave side is the board pins plus the execution unit.
interface chip8_keypad_scanner_if #(
    parameter int NUM_ROWS = 4,
    parameter int NUM_COLS = 4
);
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
    localparam int KEY_W    = $clog2(NUM_KEYS);

    logic [NUM_ROWS-1:0] row_in;
    logic [NUM_COLS-1:0] col_out;
    logic [NUM_KEYS-1:0] key_state_out;
    logic [KEY_W-1:0]    any_key_out;
    logic                valid_key_out;
    logic                press_valid_out;
    logic [KEY_W-1:0]    press_key_out;
    logic                scan_done_out;

    modport master (
        input  row_in,
        output col_out, key_state_out, any_key_out, valid_key_out,
        output press_valid_out, press_key_out, scan_done_out
    );

    modport slave (
        output row_in,
        input  col_out, key_state_out, any_key_out, valid_key_out,
        input  press_valid_out, press_key_out, scan_done_out
    );
endinterface

// File: rtl/chip8_keypad_scanner.sv
// Matrix keypad scanner: walks one active-low column at a time, samples the rows,
// debounces whole-scan bitmaps and reports held keys plus one-cycle press events.
module chip8_keypad_scanner #(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_COLS       = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    chip8_keypad_scanner_if.master kp
);
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
    localparam int KEY_W    = $clog2(NUM_KEYS);
    localparam int COL_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int SET_W    = $clog2(SETTLE_CYCLES + 1);
    localparam int CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

    typedef enum logic [1:0] {DRIVE, SETTLE, SAMPLE, COMMIT} state_t;

    state_t              state;
    logic [COL_W-1:0]    col_idx;
    logic [SET_W-1:0]    settle_cnt;
    logic [CNT_W-1:0]    deb_cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [NUM_ROWS-1:0] row_meta;
    logic [NUM_ROWS-1:0] row_sync;
    logic [NUM_KEYS-1:0] raw;
    logic [NUM_KEYS-1:0] prev_raw;
    logic [NUM_KEYS-1:0] raw_sampled;
    logic [NUM_KEYS-1:0] new_keys;

    function automatic logic [KEY_W-1:0] lowest_index(input logic [NUM_KEYS-1:0] v);
        logic [KEY_W-1:0] idx;
        idx = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--)
            if (v[k]) idx = KEY_W'(k);
        return idx;
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= kp.row_in;
            row_sync <= row_meta;
        end
    end

    // Rows are active-low, so a 0 on row r while column c is driven means key r*NUM_COLS+c is down.
    always_comb begin
        raw_sampled = raw;
        for (int r = 0; r < NUM_ROWS; r++)
            for (int c = 0; c < NUM_COLS; c++)
                if (COL_W'(c) == col_idx) raw_sampled[r*NUM_COLS + c] = ~row_sync[r];
    end

    always_comb begin
        if (raw != prev_raw)      cnt_next = CNT_W'(1);
        else if (deb_cnt == CNT_MAX) cnt_next = CNT_MAX;
        else                      cnt_next = deb_cnt + CNT_W'(1);
    end

    assign new_keys = raw & ~kp.key_state_out;

    // The last column stays driven through COMMIT, so it is low one cycle longer than the others.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state              <= DRIVE;
            col_idx            <= '0;
            settle_cnt         <= '0;
            deb_cnt            <= '0;
            raw                <= '0;
            prev_raw           <= '0;
            kp.col_out         <= '1;
            kp.key_state_out   <= '0;
            kp.any_key_out     <= '0;
            kp.valid_key_out   <= 1'b0;
            kp.press_valid_out <= 1'b0;
            kp.press_key_out   <= '0;
            kp.scan_done_out   <= 1'b0;
        end else begin
            kp.press_valid_out <= 1'b0;
            kp.scan_done_out   <= 1'b0;
            kp.any_key_out     <= lowest_index(kp.key_state_out);
            kp.valid_key_out   <= $onehot(kp.key_state_out);
            case (state)
                DRIVE: begin
                    kp.col_out <= ~(NUM_COLS'(1) << col_idx);
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + SET_W'(1);
                    if (settle_cnt == SET_LAST) state <= SAMPLE;
                end
                SAMPLE: begin
                    raw <= raw_sampled;
                    if (col_idx == COL_LAST) begin
                        col_idx          <= '0;
                        kp.scan_done_out <= 1'b1;
                        state            <= COMMIT;
                    end else begin
                        col_idx <= col_idx + COL_W'(1);
                        state   <= DRIVE;
                    end
                end
                COMMIT: begin
                    deb_cnt  <= cnt_next;
                    prev_raw <= raw;
                    if (cnt_next == CNT_MAX) begin
                        kp.key_state_out <= raw;
                        if (new_keys != '0) begin
                            kp.press_valid_out <= 1'b1;
                            kp.press_key_out   <= lowest_index(new_keys);
                        end
                    end
                    state <= DRIVE;
                end
                default: state <= DRIVE;
            endcase
        end
    end
endmodule

// File: tb/tb_chip8_keypad_scanner.sv
// Directed bench for the keypad scanner: a small pin model closes the row/column matrix
// and each scenario checks scan timing, debouncing, press events and reset recovery.
module tb_chip8_keypad_scanner;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [15:0] keys_held;
    logic [3:0]  row_drive;
    int          compare_count  = 0;
    int          mismatch_count = 0;
    int          press_seen     = 0;

    chip8_keypad_scanner_if #(.NUM_ROWS(4), .NUM_COLS(4)) bus ();

    chip8_keypad_scanner #(
        .NUM_ROWS(4), .NUM_COLS(4), .SETTLE_CYCLES(4), .DEBOUNCE_SCANS(3)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .kp     (bus)
    );

    always #5 clk_in = ~clk_in;

    // A held key pulls its row low only while its column is being driven low.
    always_comb begin
        row_drive = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys_held[r*4 + c] && (bus.col_out[c] == 1'b0)) row_drive[r] = 1'b0;
    end
    assign bus.row_in = row_drive;

    always @(negedge clk_in)
        if (bus.press_valid_out === 1'b1) press_seen <= press_seen + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] keys);
        keys_held = keys;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_col_out"},     32'(bus.col_out),         32'hF);
        checkOutput({tag, "_key_state"},   32'(bus.key_state_out),   32'h0);
        checkOutput({tag, "_any_key"},     32'(bus.any_key_out),     32'h0);
        checkOutput({tag, "_valid_key"},   32'(bus.valid_key_out),   32'h0);
        checkOutput({tag, "_press_valid"}, 32'(bus.press_valid_out), 32'h0);
        checkOutput({tag, "_press_key"},   32'(bus.press_key_out),   32'h0);
        checkOutput({tag, "_scan_done"},   32'(bus.scan_done_out),   32'h0);
    endtask

    // Returns on the falling edge inside the COMMIT cycle of the next scan.
    task automatic waitScanDone();
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!bus.scan_done_out && n < 40);
        checkOutput("scan_done_within_bound", 32'(bus.scan_done_out), 32'd1);
    endtask

    // Cycle t counts from reset release: column (t'-1)/6 is low for t' = t mod 25 in 1..24,
    // and column 3 stays low through the COMMIT/DRIVE cycle t' = 0 after the first scan.
    function automatic logic [3:0] expColOut(input int t);
        int         tp;
        logic [3:0] one_hot;
        if (t == 0) return 4'hF;
        tp = t % 25;
        if (tp == 0) return 4'h7;
        one_hot = 4'b0001 << ((tp - 1) / 6);
        return ~one_hot;
    endfunction

    initial begin
        int press_base;
        int first_done;

        rst_in = 1'b1;
        applyStimulus(16'h0000);
        repeat (3) @(negedge clk_in);
        checkReset("t0_reset");

        // Idle scanning: column walk, scan_done period, quiet key outputs.
        rst_in = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (t > 0) @(negedge clk_in);
            checkOutput("t1_col_out", 32'(bus.col_out), 32'(expColOut(t)));
            checkOutput("t1_scan_done", 32'(bus.scan_done_out), ((t % 25) == 24) ? 32'd1 : 32'd0);
            checkOutput("t1_keys_quiet",
                        32'({bus.key_state_out, bus.any_key_out, bus.valid_key_out, bus.press_valid_out}),
                        32'd0);
        end

        // Hold key 5 (row 1, column 1).
        applyStimulus(16'h0020);
        press_base = press_seen;
        repeat (2) waitScanDone();
        @(negedge clk_in);
        checkOutput("t2_no_early_commit", 32'(bus.key_state_out), 32'h0);
        waitScanDone();
        @(negedge clk_in);
        checkOutput("t2_key_state", 32'(bus.key_state_out), 32'h0020);
        checkOutput("t2_press_valid", 32'(bus.press_valid_out), 32'd1);
        checkOutput("t2_press_key", 32'(bus.press_key_out), 32'd5);
        checkOutput("t2_any_key_lag", 32'(bus.any_key_out), 32'd0);
        @(negedge clk_in);
        checkOutput("t2_press_one_cycle", 32'(bus.press_valid_out), 32'd0);
        checkOutput("t2_any_key", 32'(bus.any_key_out), 32'd5);
        checkOutput("t2_valid_key", 32'(bus.valid_key_out), 32'd1);
        repeat (2) waitScanDone();
        @(negedge clk_in);
        checkOutput("t2_single_press", 32'(press_seen - press_base), 32'd1);
        checkOutput("t2_still_held", 32'(bus.key_state_out), 32'h0020);
        checkOutput("t2_press_key_held", 32'(bus.press_key_out), 32'd5);

        // Release key 5: the bitmap clears after three scans with no event.
        waitScanDone();
        applyStimulus(16'h0000);
        press_base = press_seen;
        repeat (2) waitScanDone();
        @(negedge clk_in);
        checkOutput("t5_not_yet_released", 32'(bus.key_state_out), 32'h0020);
        waitScanDone();
        @(negedge clk_in);
        checkOutput("t5_key_state", 32'(bus.key_state_out), 32'h0);
        @(negedge clk_in);
        checkOutput("t5_valid_key", 32'(bus.valid_key_out), 32'd0);
        checkOutput("t5_any_key", 32'(bus.any_key_out), 32'd0);
        checkOutput("t5_no_release_event", 32'(press_seen - press_base), 32'd0);

        // Bounce key 5 on alternate scans, then hold it.
        waitScanDone();
        press_base = press_seen;
        for (int i = 0; i < 6; i++) begin
            applyStimulus((i % 2 == 0) ? 16'h0020 : 16'h0000);
            waitScanDone();
            checkOutput("t3_bounce_state", 32'(bus.key_state_out), 32'h0);
        end
        applyStimulus(16'h0020);
        repeat (2) waitScanDone();
        @(negedge clk_in);
        checkOutput("t3_no_commit_two_stable", 32'(bus.key_state_out), 32'h0);
        checkOutput("t3_no_bounce_press", 32'(press_seen - press_base), 32'd0);
        waitScanDone();
        @(negedge clk_in);
        checkOutput("t3_commit_third_stable", 32'(bus.key_state_out), 32'h0020);
        checkOutput("t3_press_valid", 32'(bus.press_valid_out), 32'd1);
        checkOutput("t3_press_key", 32'(bus.press_key_out), 32'd5);

        // Reset in the middle of column 2 settling, with key 5 committed.
        repeat (14) @(negedge clk_in);
        checkOutput("t6_mid_col2", 32'(bus.col_out), 32'hB);
        checkOutput("t6_key5_committed", 32'(bus.key_state_out), 32'h0020);
        rst_in = 1'b1;
        applyStimulus(16'h0204);
        @(negedge clk_in);
        checkReset("t6_reset");
        rst_in = 1'b0;
        checkOutput("t6_restart_idle", 32'(bus.col_out), 32'hF);
        @(negedge clk_in);
        checkOutput("t6_restart_col0", 32'(bus.col_out), 32'hE);
        first_done = -1;
        for (int t = 2; t < 40 && first_done < 0; t++) begin
            @(negedge clk_in);
            if (bus.scan_done_out) first_done = t;
        end
        checkOutput("t6_first_scan_done", 32'(first_done), 32'd24);

        // Keys 2 and 9 held since reset release: commit on the third scan.
        press_base = press_seen;
        waitScanDone();
        @(negedge clk_in);
        checkOutput("t4_no_early_commit", 32'(bus.key_state_out), 32'h0);
        waitScanDone();
        @(negedge clk_in);
        checkOutput("t4_key_state", 32'(bus.key_state_out), 32'h0204);
        checkOutput("t4_press_valid", 32'(bus.press_valid_out), 32'd1);
        checkOutput("t4_press_key", 32'(bus.press_key_out), 32'd2);
        @(negedge clk_in);
        checkOutput("t4_any_key", 32'(bus.any_key_out), 32'd2);
        checkOutput("t4_valid_key", 32'(bus.valid_key_out), 32'd0);
        waitScanDone();
        @(negedge clk_in);
        checkOutput("t4_single_press", 32'(press_seen - press_base), 32'd1);
        checkOutput("t4_press_key_held", 32'(bus.press_key_out), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end
endmodule
